sram_burst_arbiter: RTL and testbench

SRAM_BURST_ARBITER -- requirements
Module: sram_burst_arbiter

---
 rtl/sram_burst_arbiter.sv | 151 +++++++++++++++
 tb/tb_sram_burst_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_burst_arbiter.sv
// Single-port SRAM arbiter between a host row port and a burst reader.
// Round-robin grant, combinational in the request cycle.
module sram_burst_arbiter #(
   parameter int BWIDTH = 256,
   parameter int AWIDTH = 10
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              H_REQ_in,
   input  logic              H_WEn_in,
   input  logic [AWIDTH-1:0] H_ADDR_in,
   input  logic [BWIDTH-1:0] H_BE_in,
   input  logic [BWIDTH-1:0] H_D_in,
   output logic              H_GNT_out,
   output logic              H_RVALID_out,
   output logic [BWIDTH-1:0] H_RDATA_out,
   input  logic              B_START_in,
   input  logic [AWIDTH-1:0] B_BASE_in,
   input  logic [AWIDTH:0]   B_LEN_in,
   output logic              B_BUSY_out,
   output logic              B_VALID_out,
   output logic [BWIDTH-1:0] B_DATA_out,
   output logic              B_DONE_out,
   output logic              SRAM_CSn_out,
   output logic              SRAM_WEn_out,
   output logic [AWIDTH-1:0] SRAM_ADDR_out,
   output logic [BWIDTH-1:0] SRAM_BE_out,
   output logic [BWIDTH-1:0] SRAM_D_out,
   input  logic [BWIDTH-1:0] SRAM_Q_in
);

   typedef enum logic {IDLE, BURST} state_t;

   state_t            state;
   state_t            state_nx;
   logic [AWIDTH-1:0] addr_q;
   logic [AWIDTH-1:0] addr_nx;
   logic [AWIDTH:0]   rem_q;
   logic [AWIDTH:0]   rem_nx;
   logic              last_burst_q;
   logic              h_rvalid_q;
   logic              b_valid_q;
   logic              b_done_q;
   logic              h_req;
   logic              b_req;
   logic              h_gnt;
   logic              b_gnt;
   logic              b_last;
   logic              zero_start;

   // Host request is masked while reset is held so no SRAM cycle leaks out.
   assign h_req = H_REQ_in & RSTn;
   assign b_req = (state == BURST);
   assign b_last = b_gnt && (rem_q == {{AWIDTH{1'b0}}, 1'b1});
   assign zero_start = (state == IDLE) && B_START_in &&
                       (B_LEN_in == '0);

   // Round-robin: on contention the side not granted last time wins.
   always_comb begin
      h_gnt = 1'b0;
      b_gnt = 1'b0;
      if (h_req && b_req) begin
         if (last_burst_q) h_gnt = 1'b1;
         else              b_gnt = 1'b1;
      end else begin
         h_gnt = h_req;
         b_gnt = b_req;
      end
   end

   // Next state, address counter and remaining-row count.
   always_comb begin
      state_nx = state;
      addr_nx  = addr_q;
      rem_nx   = rem_q;
      case (state)
         IDLE: begin
            if (B_START_in && (B_LEN_in != '0)) begin
               state_nx = BURST;
               addr_nx  = B_BASE_in;
               rem_nx   = B_LEN_in;
            end
         end
         BURST: begin
            if (b_gnt) begin
               addr_nx = addr_q + 1'b1;
               rem_nx  = rem_q - 1'b1;
               if (b_last) state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // FSM and burst counters.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state  <= IDLE;
         addr_q <= '0;
         rem_q  <= '0;
      end else begin
         state  <= state_nx;
         addr_q <= addr_nx;
         rem_q  <= rem_nx;
      end
   end

   // Last-grant flag and one-cycle response strobes.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         last_burst_q <= 1'b1;
         h_rvalid_q   <= 1'b0;
         b_valid_q    <= 1'b0;
         b_done_q     <= 1'b0;
      end else begin
         if (h_gnt)      last_burst_q <= 1'b0;
         else if (b_gnt) last_burst_q <= 1'b1;
         h_rvalid_q <= h_gnt & H_WEn_in;
         b_valid_q  <= b_gnt;
         b_done_q   <= b_last | zero_start;
      end
   end

   // SRAM pin mux; idle pins are parked at inactive values.
   always_comb begin
      SRAM_CSn_out  = 1'b1;
      SRAM_WEn_out  = 1'b1;
      SRAM_ADDR_out = '0;
      SRAM_BE_out   = '0;
      SRAM_D_out    = '0;
      if (h_gnt) begin
         SRAM_CSn_out  = 1'b0;
         SRAM_WEn_out  = H_WEn_in;
         SRAM_ADDR_out = H_ADDR_in;
         SRAM_BE_out   = H_BE_in;
         SRAM_D_out    = H_D_in;
      end else if (b_gnt) begin
         SRAM_CSn_out  = 1'b0;
         SRAM_ADDR_out = addr_q;
      end
   end

   assign H_GNT_out    = h_gnt;
   assign H_RVALID_out = h_rvalid_q;
   assign H_RDATA_out  = h_rvalid_q ? SRAM_Q_in : '0;
   assign B_BUSY_out   = b_req;
   assign B_VALID_out  = b_valid_q;
   assign B_DATA_out   = b_valid_q ? SRAM_Q_in : '0;
   assign B_DONE_out   = b_done_q;

endmodule

// File: tb/tb_sram_burst_arbiter.sv
// Scoreboard bench for sram_burst_arbiter with a behavioural SRAM.
// Expected events carry the cycle they must appear in.
module tb_sram_burst_arbiter;

   localparam int BW = 256;
   localparam int AW = 10;

   logic          CLK = 1'b0;
   logic          RSTn = 1'b0;
   logic          H_REQ_in = 1'b0;
   logic          H_WEn_in = 1'b1;
   logic [AW-1:0] H_ADDR_in = '0;
   logic [BW-1:0] H_BE_in = '0;
   logic [BW-1:0] H_D_in = '0;
   logic          H_GNT_out;
   logic          H_RVALID_out;
   logic [BW-1:0] H_RDATA_out;
   logic          B_START_in = 1'b0;
   logic [AW-1:0] B_BASE_in = '0;
   logic [AW:0]   B_LEN_in = '0;
   logic          B_BUSY_out;
   logic          B_VALID_out;
   logic [BW-1:0] B_DATA_out;
   logic          B_DONE_out;
   logic          SRAM_CSn_out;
   logic          SRAM_WEn_out;
   logic [AW-1:0] SRAM_ADDR_out;
   logic [BW-1:0] SRAM_BE_out;
   logic [BW-1:0] SRAM_D_out;
   logic [BW-1:0] SRAM_Q_in;

   sram_burst_arbiter #(.BWIDTH(BW), .AWIDTH(AW)) dut (
      .CLK(CLK), .RSTn(RSTn),
      .H_REQ_in(H_REQ_in), .H_WEn_in(H_WEn_in),
      .H_ADDR_in(H_ADDR_in), .H_BE_in(H_BE_in),
      .H_D_in(H_D_in), .H_GNT_out(H_GNT_out),
      .H_RVALID_out(H_RVALID_out), .H_RDATA_out(H_RDATA_out),
      .B_START_in(B_START_in), .B_BASE_in(B_BASE_in),
      .B_LEN_in(B_LEN_in), .B_BUSY_out(B_BUSY_out),
      .B_VALID_out(B_VALID_out), .B_DATA_out(B_DATA_out),
      .B_DONE_out(B_DONE_out), .SRAM_CSn_out(SRAM_CSn_out),
      .SRAM_WEn_out(SRAM_WEn_out), .SRAM_ADDR_out(SRAM_ADDR_out),
      .SRAM_BE_out(SRAM_BE_out), .SRAM_D_out(SRAM_D_out),
      .SRAM_Q_in(SRAM_Q_in)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int            cyc;
      logic          wen;
      logic [AW-1:0] addr;
      logic [BW-1:0] be;
      logic [BW-1:0] d;
   } acc_t;

   typedef struct {
      int            cyc;
      logic [BW-1:0] d;
   } rd_t;

   acc_t acc_q[$];
   rd_t  hq[$];
   rd_t  bq[$];
   int   dq[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [BW-1:0] mem [1<<AW];
   logic [BW-1:0] ones;
   logic [BW-1:0] aa;

   function automatic logic [BW-1:0] pat(input int i);
      logic [31:0] w;
      w = 32'hC0DE_0000 + 32'(i);
      return {8{w}};
   endfunction

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = pat(i);
      SRAM_Q_in = '0;
   end

   // Behavioural SRAM: read data appears the cycle after the access edge.
   always @(posedge CLK) begin
      if (!SRAM_CSn_out) begin
         if (!SRAM_WEn_out)
            mem[SRAM_ADDR_out] <= (mem[SRAM_ADDR_out] & ~SRAM_BE_out) |
                                  (SRAM_D_out & SRAM_BE_out);
         else
            SRAM_Q_in <= mem[SRAM_ADDR_out];
      end
   end

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string nm,
                      input logic [BW-1:0] act,
                      input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic unexp(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
   endtask

   // Monitor: every DUT event must match the head of its queue.
   always @(negedge CLK) begin
      acc_t a;
      rd_t  r;
      int   c;
      if (RSTn) begin
         if (!SRAM_CSn_out) begin
            if (acc_q.size() == 0) unexp("access");
            else begin
               a = acc_q.pop_front();
               chk("acc_cyc", 256'(cyc), 256'(a.cyc));
               chk("acc_addr", 256'(SRAM_ADDR_out), 256'(a.addr));
               chk("acc_wen", 256'(SRAM_WEn_out), 256'(a.wen));
               chk("acc_be", SRAM_BE_out, a.be);
               chk("acc_d", SRAM_D_out, a.d);
            end
         end
         if (H_RVALID_out) begin
            if (hq.size() == 0) unexp("h_rvalid");
            else begin
               r = hq.pop_front();
               chk("h_cyc", 256'(cyc), 256'(r.cyc));
               chk("h_rdata", H_RDATA_out, r.d);
            end
         end
         if (B_VALID_out) begin
            if (bq.size() == 0) unexp("b_valid");
            else begin
               r = bq.pop_front();
               chk("b_cyc", 256'(cyc), 256'(r.cyc));
               chk("b_data", B_DATA_out, r.d);
            end
         end
         if (B_DONE_out) begin
            if (dq.size() == 0) unexp("b_done");
            else begin
               c = dq.pop_front();
               chk("done_cyc", 256'(cyc), 256'(c));
            end
         end
      end
   end

   function automatic void push_acc(input int c, input logic w,
                                    input logic [AW-1:0] ad,
                                    input logic [BW-1:0] be,
                                    input logic [BW-1:0] d);
      acc_t a;
      a.cyc = c; a.wen = w; a.addr = ad; a.be = be; a.d = d;
      acc_q.push_back(a);
   endfunction

   function automatic void push_rd(input bit host, input int c,
                                   input logic [BW-1:0] d);
      rd_t r;
      r.cyc = c; r.d = d;
      if (host) hq.push_back(r);
      else      bq.push_back(r);
   endfunction

   // Burst of rows base..base+n-1 started in cycle s, no contention.
   function automatic void push_burst(input int s, input int base,
                                      input int n);
      for (int i = 0; i < n; i++) begin
         push_acc(s + 1 + i, 1'b1, AW'((base + i) % (1 << AW)), '0, '0);
         push_rd(1'b0, s + 2 + i, pat((base + i) % (1 << AW)));
      end
      dq.push_back(s + 1 + n);
   endfunction

   // Entered just after a posedge; returns just after the grant edge.
   task automatic host_op(input logic w, input logic [AW-1:0] ad,
                          input logic [BW-1:0] be,
                          input logic [BW-1:0] d);
      bit got;
      got = 0;
      H_REQ_in = 1'b1; H_WEn_in = w; H_ADDR_in = ad;
      H_BE_in = be; H_D_in = d;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge CLK);
         if (H_GNT_out) got = 1;
         else if (k < 19) @(posedge CLK);
      end
      if (!got) unexp("host_grant_timeout");
      @(posedge CLK); #1;
      H_REQ_in = 1'b0; H_BE_in = '0; H_D_in = '0;
   endtask

   task automatic start(input int base, input int len);
      B_START_in = 1'b1;
      B_BASE_in = AW'(base);
      B_LEN_in = (AW+1)'(len);
      @(posedge CLK); #1;
      B_START_in = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic chk_reset_outs();
      chk("rst_gnt", 256'(H_GNT_out), 256'(0));
      chk("rst_rvalid", 256'(H_RVALID_out), 256'(0));
      chk("rst_rdata", H_RDATA_out, '0);
      chk("rst_busy", 256'(B_BUSY_out), 256'(0));
      chk("rst_bvalid", 256'(B_VALID_out), 256'(0));
      chk("rst_bdata", B_DATA_out, '0);
      chk("rst_done", 256'(B_DONE_out), 256'(0));
      chk("rst_csn", 256'(SRAM_CSn_out), 256'(1));
      chk("rst_wen", 256'(SRAM_WEn_out), 256'(1));
      chk("rst_addr", 256'(SRAM_ADDR_out), 256'(0));
      chk("rst_be", SRAM_BE_out, '0);
      chk("rst_d", SRAM_D_out, '0);
   endtask

   initial begin
      int n;
      ones = '1;
      aa = {32{8'hAA}};

      #1;
      chk_reset_outs();
      step(3);
      RSTn = 1'b1;
      step(1);

      // host write row 5 then read it back
      n = cyc;
      push_acc(n, 1'b0, 10'd5, ones, aa);
      host_op(1'b0, 10'd5, ones, aa);
      n = cyc;
      push_acc(n, 1'b1, 10'd5, ones, '0);
      push_rd(1'b1, n + 1, aa);
      host_op(1'b1, 10'd5, ones, '0);
      step(3);

      // burst 3..6, row 5 now holds the written pattern
      n = cyc;
      for (int i = 0; i < 4; i++) begin
         push_acc(n + 1 + i, 1'b1, AW'(3 + i), '0, '0);
         push_rd(1'b0, n + 2 + i, (i == 2) ? aa : pat(3 + i));
      end
      dq.push_back(n + 5);
      start(3, 4);
      step(6);
      chk("busy_after_burst", 256'(B_BUSY_out), 256'(0));

      // reset, then burst 1..4 contending with four host reads
      RSTn = 1'b0;
      step(1);
      RSTn = 1'b1;
      step(1);
      n = cyc;
      for (int i = 0; i < 4; i++) begin
         push_acc(n + 1 + 2*i, 1'b1, AW'(10 + i), '0, '0);
         push_rd(1'b1, n + 2 + 2*i, pat(10 + i));
         push_acc(n + 2 + 2*i, 1'b1, AW'(1 + i), '0, '0);
         push_rd(1'b0, n + 3 + 2*i, pat(1 + i));
      end
      dq.push_back(n + 9);
      start(1, 4);
      for (int i = 0; i < 4; i++)
         host_op(1'b1, AW'(10 + i), '0, '0);
      step(4);
      chk("busy_after_rr", 256'(B_BUSY_out), 256'(0));

      // address wrap 1022, 1023, 0
      n = cyc;
      push_burst(n, 1022, 3);
      start(1022, 3);
      step(5);

      // zero-length start: no access, done next cycle
      n = cyc;
      dq.push_back(n + 1);
      start(50, 0);
      @(negedge CLK);
      chk("busy_len0", 256'(B_BUSY_out), 256'(0));
      step(3);

      // start during burst is ignored
      n = cyc;
      push_burst(n, 20, 2);
      start(20, 2);
      start(40, 5);
      step(8);
      chk("busy_after_ign", 256'(B_BUSY_out), 256'(0));

      // reset after the 2nd burst grant aborts the burst
      n = cyc;
      push_acc(n + 1, 1'b1, 10'd100, '0, '0);
      push_acc(n + 2, 1'b1, 10'd101, '0, '0);
      push_rd(1'b0, n + 2, pat(100));
      start(100, 5);
      step(2);
      H_REQ_in = 1'b1;
      H_WEn_in = 1'b1;
      RSTn = 1'b0;
      #1;
      chk_reset_outs();
      step(2);
      H_REQ_in = 1'b0;
      RSTn = 1'b1;
      step(8);
      chk("busy_after_abort", 256'(B_BUSY_out), 256'(0));

      chk("acc_q_empty", 256'(acc_q.size()), 256'(0));
      chk("hq_empty", 256'(hq.size()), 256'(0));
      chk("bq_empty", 256'(bq.size()), 256'(0));
      chk("dq_empty", 256'(dq.size()), 256'(0));

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
